ex_mem_branch_stage: RTL and testbench

EX/MEM pipeline boundary for the pipelined RV32 core: registers the Execute stage results (ALU result, store data, destination register, memory/writeback controls) toward the Memory stage and resolves conditional branches from the Execute zero flag and branch target. A taken branch produces a one-cycle fetch redirect plus flush requests for IF/ID and ID/EX, and squashes the wrong-path instruction arriving from Execute. It also keeps branch and taken-branch performance counters.

---
 rtl/ex_mem_branch_stage_if.sv | 50 +++++
 rtl/ex_mem_branch_stage.sv | 67 ++++++
 tb/tb_ex_mem_branch_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_branch_stage_if.sv
// EX-to-MEM boundary bundle: Execute results and controls in, Memory-stage
// registers, branch redirect and performance counters out.
interface ex_mem_branch_stage_if #(parameter int width = 32);
  logic             ex_valid;
  logic [width-1:0] ex_alu_out;
  logic [width-1:0] ex_rd2;
  logic [width-1:0] ex_branch_target;
  logic             ex_zero;
  logic [2:0]       ex_funct3;
  logic [4:0]       ex_rd;
  logic             ex_branch;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_reg_write;
  logic             ex_mem_to_reg;
  logic             mem_stall;
  logic             ex_ready;
  logic             mem_valid;
  logic             mem_mem_read;
  logic             mem_mem_write;
  logic             mem_reg_write;
  logic             mem_mem_to_reg;
  logic [width-1:0] mem_alu_out;
  logic [width-1:0] mem_wdata;
  logic [4:0]       mem_rd;
  logic             redirect_valid;
  logic [width-1:0] redirect_pc;
  logic             flush_ifid;
  logic             flush_idex;
  logic [31:0]      branch_count;
  logic [31:0]      taken_count;

  modport master (
    output ex_valid, ex_alu_out, ex_rd2, ex_branch_target, ex_zero, ex_funct3,
           ex_rd, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_mem_to_reg, mem_stall,
    input  ex_ready, mem_valid, mem_mem_read, mem_mem_write, mem_reg_write,
           mem_mem_to_reg, mem_alu_out, mem_wdata, mem_rd, redirect_valid,
           redirect_pc, flush_ifid, flush_idex, branch_count, taken_count
  );

  modport slave (
    input  ex_valid, ex_alu_out, ex_rd2, ex_branch_target, ex_zero, ex_funct3,
           ex_rd, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_mem_to_reg, mem_stall,
    output ex_ready, mem_valid, mem_mem_read, mem_mem_write, mem_reg_write,
           mem_mem_to_reg, mem_alu_out, mem_wdata, mem_rd, redirect_valid,
           redirect_pc, flush_ifid, flush_idex, branch_count, taken_count
  );
endinterface

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with BEQ/BNE resolution, one-cycle fetch redirect,
// wrong-path squash and branch/taken performance counters.
module ex_mem_branch_stage #(
  parameter int width = 32
) (
  input logic                  clk,
  input logic                  rst,
  ex_mem_branch_stage_if.slave bus
);

  logic             squash_pending;
  logic             eff_valid;
  logic             is_branch;
  logic             taken;
  logic             redirect_valid_q;
  logic [width-1:0] redirect_pc_q;

  always_comb begin
    eff_valid = bus.ex_valid & ~squash_pending;
    is_branch = eff_valid & bus.ex_branch;
    taken     = is_branch &
                (((bus.ex_funct3 == 3'b000) &  bus.ex_zero) |
                 ((bus.ex_funct3 == 3'b001) & ~bus.ex_zero));
  end

  assign bus.ex_ready       = ~bus.mem_stall;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_ifid     = redirect_valid_q;
  assign bus.flush_idex     = redirect_valid_q;

  // EX -> MEM boundary: everything holds on stall except the redirect pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_valid      <= 1'b0;
      bus.mem_mem_read   <= 1'b0;
      bus.mem_mem_write  <= 1'b0;
      bus.mem_reg_write  <= 1'b0;
      bus.mem_mem_to_reg <= 1'b0;
      bus.mem_alu_out    <= '0;
      bus.mem_wdata      <= '0;
      bus.mem_rd         <= '0;
      bus.branch_count   <= '0;
      bus.taken_count    <= '0;
      squash_pending     <= 1'b0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
    end else if (bus.mem_stall) begin
      redirect_valid_q   <= 1'b0;
    end else begin
      bus.mem_valid      <= eff_valid;
      bus.mem_mem_read   <= bus.ex_mem_read   & eff_valid;
      bus.mem_mem_write  <= bus.ex_mem_write  & eff_valid;
      bus.mem_reg_write  <= bus.ex_reg_write  & eff_valid;
      bus.mem_mem_to_reg <= bus.ex_mem_to_reg & eff_valid;
      bus.mem_alu_out    <= bus.ex_alu_out;
      bus.mem_wdata      <= bus.ex_rd2;
      bus.mem_rd         <= bus.ex_rd;
      squash_pending     <= taken;
      redirect_valid_q   <= taken;
      if (taken) redirect_pc_q <= bus.ex_branch_target;
      if (is_branch) bus.branch_count <= bus.branch_count + 32'd1;
      if (taken) bus.taken_count <= bus.taken_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Directed bench for ex_mem_branch_stage: vector table for single-cycle
// captures plus hand sequences for stall, redirect and reset interaction.
module tb_ex_mem_branch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_mem_branch_stage_if #(.width(32)) bus ();

  ex_mem_branch_stage #(.width(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        valid;
    logic        br;
    logic [2:0]  f3;
    logic        zero;
    logic [3:0]  ctrl;   // {mem_read, mem_write, reg_write, mem_to_reg}
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [31:0] tgt;
    logic        e_valid;
    logic [3:0]  e_ctrl;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic br, input logic [2:0] f3,
                       input logic zero, input logic [3:0] ctrl, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rd2, input logic [31:0] tgt);
    bus.ex_valid         = valid;
    bus.ex_branch        = br;
    bus.ex_funct3        = f3;
    bus.ex_zero          = zero;
    {bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_mem_to_reg} = ctrl;
    bus.ex_rd            = rd;
    bus.ex_alu_out       = alu;
    bus.ex_rd2           = rd2;
    bus.ex_branch_target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_redirect(input string name, input logic rv, input logic [31:0] rpc);
    chk({name, ".rv"},    {31'd0, bus.redirect_valid}, {31'd0, rv});
    chk({name, ".fifd"},  {31'd0, bus.flush_ifid},     {31'd0, rv});
    chk({name, ".fidex"}, {31'd0, bus.flush_idex},     {31'd0, rv});
    chk({name, ".rpc"},   bus.redirect_pc, rpc);
  endtask

  task automatic chk_counts(input string name, input logic [31:0] b, input logic [31:0] t);
    chk({name, ".bcnt"}, bus.branch_count, b);
    chk({name, ".tcnt"}, bus.taken_count, t);
  endtask

  initial begin
    // inputs: valid br f3 zero ctrl rd alu rd2 tgt | expected: valid ctrl rv rpc
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 1'b0, 4'b0010, 5'd1, 32'h11,  32'h22,        32'h0,   1'b1, 4'b0010, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'b010, 1'b0, 4'b0100, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'h0,   1'b1, 4'b0100, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'b010, 1'b0, 4'b1011, 5'd7, 32'h200, 32'h0,         32'h0,   1'b1, 4'b1011, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 3'b000, 1'b0, 4'b0010, 5'd9, 32'h333, 32'h3,         32'h0,   1'b0, 4'b0000, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 3'b001, 1'b1, 4'b0000, 5'd0, 32'h0,   32'h0,         32'h80,  1'b1, 4'b0000, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 1'b0, 4'b0010, 5'd4, 32'h44,  32'h0,         32'h0,   1'b1, 4'b0010, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 3'b000, 1'b1, 4'b0000, 5'd0, 32'h0,   32'h0,         32'h40,  1'b1, 4'b0000, 1'b1, 32'h40};
    vecs[7]  = '{1'b1, 1'b0, 3'b000, 1'b0, 4'b0010, 5'd5, 32'h55,  32'h0,         32'h0,   1'b0, 4'b0000, 1'b0, 32'h40};
    vecs[8]  = '{1'b1, 1'b0, 3'b000, 1'b0, 4'b0010, 5'd6, 32'h66,  32'h0,         32'h0,   1'b1, 4'b0010, 1'b0, 32'h40};
    vecs[9]  = '{1'b1, 1'b1, 3'b001, 1'b0, 4'b0000, 5'd0, 32'h0,   32'h0,         32'h100, 1'b1, 4'b0000, 1'b1, 32'h100};
    vecs[10] = '{1'b1, 1'b1, 3'b000, 1'b1, 4'b0000, 5'd0, 32'h0,   32'h0,         32'h200, 1'b0, 4'b0000, 1'b0, 32'h100};
    vecs[11] = '{1'b1, 1'b1, 3'b100, 1'b1, 4'b0000, 5'd0, 32'h0,   32'h0,         32'h300, 1'b1, 4'b0000, 1'b0, 32'h100};
    vecs[12] = '{1'b0, 1'b1, 3'b000, 1'b1, 4'b0000, 5'd0, 32'h0,   32'h0,         32'h400, 1'b0, 4'b0000, 1'b0, 32'h100};

    // Reset held with a live taken branch on the inputs
    bus.mem_stall = 1'b0;
    drive(1'b1, 1'b1, 3'b000, 1'b1, 4'b1111, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h40);
    rst = 1'b1;
    step();
    step();
    chk("rst.valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst.ctrl", {28'd0, bus.mem_mem_read, bus.mem_mem_write, bus.mem_reg_write, bus.mem_mem_to_reg}, 32'd0);
    chk("rst.alu", bus.mem_alu_out, 32'd0);
    chk("rst.wdata", bus.mem_wdata, 32'd0);
    chk("rst.rd", {27'd0, bus.mem_rd}, 32'd0);
    chk_redirect("rst", 1'b0, 32'd0);
    chk_counts("rst", 32'd0, 32'd0);
    chk("rst.ready", {31'd0, bus.ex_ready}, 32'd1);
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 1'b0, 4'b0000, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk("idle.valid", {31'd0, bus.mem_valid}, 32'd0);
    chk_redirect("idle", 1'b0, 32'd0);
    chk_counts("idle", 32'd0, 32'd0);

    // Table of single-cycle captures
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].valid, vecs[i].br, vecs[i].f3, vecs[i].zero, vecs[i].ctrl,
            vecs[i].rd, vecs[i].alu, vecs[i].rd2, vecs[i].tgt);
      step();
      chk($sformatf("v%0d.valid", i), {31'd0, bus.mem_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d.ctrl", i),
          {28'd0, bus.mem_mem_read, bus.mem_mem_write, bus.mem_reg_write, bus.mem_mem_to_reg},
          {28'd0, vecs[i].e_ctrl});
      chk($sformatf("v%0d.alu", i), bus.mem_alu_out, vecs[i].alu);
      chk($sformatf("v%0d.wdata", i), bus.mem_wdata, vecs[i].rd2);
      chk($sformatf("v%0d.rd", i), {27'd0, bus.mem_rd}, {27'd0, vecs[i].rd});
      chk_redirect($sformatf("v%0d", i), vecs[i].e_rv, vecs[i].e_rpc);
    end
    chk_counts("table", 32'd4, 32'd2);

    // Stall hold: captured ALU op survives 3 stall cycles of changing inputs
    drive(1'b1, 1'b0, 3'b000, 1'b0, 4'b0010, 5'd3, 32'h1234, 32'h0, 32'h0);
    step();
    chk("sh.alu0", bus.mem_alu_out, 32'h1234);
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 3'b000, 1'b1, 4'b1111, 5'(10 + i), 32'hAAAA + i, 32'h77, 32'h500);
      #1;
      chk($sformatf("sh%0d.ready", i), {31'd0, bus.ex_ready}, 32'd0);
      step();
      chk($sformatf("sh%0d.alu", i), bus.mem_alu_out, 32'h1234);
      chk($sformatf("sh%0d.rd", i), {27'd0, bus.mem_rd}, 32'd3);
      chk($sformatf("sh%0d.rw", i), {31'd0, bus.mem_reg_write}, 32'd1);
      chk_redirect($sformatf("sh%0d", i), 1'b0, 32'h100);
      chk_counts($sformatf("sh%0d", i), 32'd4, 32'd2);
    end
    bus.mem_stall = 1'b0;
    drive(1'b1, 1'b0, 3'b000, 1'b0, 4'b0010, 5'd8, 32'h5678, 32'h0, 32'h0);
    #1;
    chk("sh.ready", {31'd0, bus.ex_ready}, 32'd1);
    step();
    chk("sh.alu", bus.mem_alu_out, 32'h5678);
    chk("sh.rd", {27'd0, bus.mem_rd}, 32'd8);
    chk("sh.valid", {31'd0, bus.mem_valid}, 32'd1);

    // Stall arriving in the redirect cycle
    drive(1'b1, 1'b1, 3'b000, 1'b1, 4'b0000, 5'd0, 32'h0, 32'h0, 32'h400);
    step();
    chk_redirect("sr.br", 1'b1, 32'h400);
    chk_counts("sr.br", 32'd5, 32'd3);
    bus.mem_stall = 1'b1;
    drive(1'b1, 1'b0, 3'b000, 1'b0, 4'b0010, 5'd11, 32'hA1, 32'h0, 32'h0);
    step();
    chk_redirect("sr.s0", 1'b0, 32'h400);
    step();
    chk_redirect("sr.s1", 1'b0, 32'h400);
    chk("sr.s1.valid", {31'd0, bus.mem_valid}, 32'd1);
    bus.mem_stall = 1'b0;
    step();
    chk("sr.a.valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("sr.a.rw", {31'd0, bus.mem_reg_write}, 32'd0);
    chk("sr.a.alu", bus.mem_alu_out, 32'hA1);
    chk_redirect("sr.a", 1'b0, 32'h400);
    drive(1'b1, 1'b0, 3'b000, 1'b0, 4'b0010, 5'd12, 32'hB2, 32'h0, 32'h0);
    step();
    chk("sr.b.valid", {31'd0, bus.mem_valid}, 32'd1);
    chk("sr.b.rw", {31'd0, bus.mem_reg_write}, 32'd1);
    chk("sr.b.rd", {27'd0, bus.mem_rd}, 32'd12);

    // Three taken branches, each followed by a squashed filler
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 3'b000, 1'b1, 4'b0000, 5'd0, 32'h0, 32'h0, 32'h1000 + 32'(i));
      step();
      chk_counts($sformatf("tc%0d", i), 32'd6 + 32'(i), 32'd4 + 32'(i));
      chk_redirect($sformatf("tc%0d", i), 1'b1, 32'h1000 + 32'(i));
      drive(1'b1, 1'b0, 3'b000, 1'b0, 4'b0010, 5'd13, 32'hC0, 32'h0, 32'h0);
      step();
      chk($sformatf("tc%0d.fill", i), {31'd0, bus.mem_valid}, 32'd0);
    end
    drive(1'b1, 1'b1, 3'b100, 1'b1, 4'b0000, 5'd0, 32'h0, 32'h0, 32'h2000);
    step();
    chk_counts("odd", 32'd9, 32'd6);
    chk_redirect("odd", 1'b0, 32'h1002);
    chk("odd.valid", {31'd0, bus.mem_valid}, 32'd1);

    // Reset during a stalled redirect cycle
    drive(1'b1, 1'b1, 3'b001, 1'b0, 4'b0000, 5'd0, 32'h9, 32'h0, 32'h3000);
    step();
    chk_redirect("rr.br", 1'b1, 32'h3000);
    bus.mem_stall = 1'b1;
    rst = 1'b1;
    step();
    chk_redirect("rr", 1'b0, 32'd0);
    chk_counts("rr", 32'd0, 32'd0);
    chk("rr.alu", bus.mem_alu_out, 32'd0);
    chk("rr.valid", {31'd0, bus.mem_valid}, 32'd0);
    rst = 1'b0;
    bus.mem_stall = 1'b0;
    drive(1'b1, 1'b0, 3'b000, 1'b0, 4'b0010, 5'd2, 32'hE0, 32'h0, 32'h0);
    step();
    chk("rr.after.valid", {31'd0, bus.mem_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
